float_point_cmp_acc: RTL
========================

FLOAT_POINT_CMP_ACC -- requirements
Module: float_point_cmp_acc

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mode  input  2  00 pair compare, 01 running max, 10 running min, 11 treated as 00.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, input handshake.
REQ-007 SHALL have ports a and b, input, W each, operands (b ignored in running modes).
REQ-008 SHALL have port in_last  input  1  marks final element of a running frame.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, output handshake.
REQ-010 SHALL have port out  output  W  result value.
REQ-011 SHALL have ports great, less, equal, unord, output, 1 each, result flags.

Function
REQ-012 SHALL accept a beat on a rising edge when in_valid and in_ready are both 1.
REQ-013 SHALL be a two-stage pipeline (operand register, result register) with global stall = out_valid && !out_ready; in_ready = !stall.
REQ-014 SHALL hold out, flags and out_valid stable while stalled.
REQ-015 SHALL, in pair mode, assert out_valid exactly 2 cycles after acceptance when not stalled; one result per beat, full throughput.
REQ-016 SHALL order values by sign-magnitude: opposite signs -> positive greater; same sign -> compare {exp,man}, reversed when negative; subnormals compared by magnitude.
REQ-017 SHALL treat +0 and -0 as equal.
REQ-018 SHALL classify NaN as exp all ones with nonzero mantissa; any NaN operand -> unord=1, great=less=equal=0.
REQ-019 SHALL, in pair mode, output the greater operand, a when equal, canonical qNaN when unordered.
REQ-020 SHALL use canonical qNaN: sign 0, exponent all ones, mantissa MSB 1, remaining bits 0.
REQ-021 SHALL latch mode on the first beat of a running frame and ignore mode until the beat with in_last=1.
REQ-022 SHALL, in running max/min, keep an accumulator updated per accepted beat; first beat loads the element.
REQ-023 SHALL produce no output for non-last beats; the in_last beat yields out_valid 2 cycles later with the final accumulator.
REQ-024 SHALL accept a single-beat frame (first and last) and output that element.
REQ-025 SHALL make a frame containing any NaN output canonical qNaN with unord=1; otherwise running output has all flags 0.
REQ-026 SHALL, on ties between +0 and -0 in running mode, keep the earlier element.
REQ-027 SHALL accept the next frame's first beat on the cycle after in_last without a bubble.

Reset
REQ-028 SHALL, while rst=1, clear out_valid, both pipeline valids, accumulator, frame-active and NaN-seen state; out=0, all flags 0.
REQ-029 SHALL drive in_ready=1 during and after reset.
REQ-030 SHALL discard any partially accumulated frame and in-flight results on reset; no output for them afterward.

Structure
REQ-031 SHALL place mode encodings and the canonical-qNaN construction function in shared package float_point_pkg.
REQ-032 SHALL implement classification and ordering as combinational sub-module float_point_cmp_core, parametrised by EXP_W/MAN_W, reused for pair compare and accumulator update.

Verification
REQ-033 SHALL cover pair mode a=0x40400000 (3.0), b=0xC0000000 (-2.0) -> great=1, out=0x40400000, two cycles later.
REQ-034 SHALL cover a=0x00000000, b=0x80000000 -> equal=1, out=0x00000000; a=0x7FC00001, b=0x3F800000 -> unord=1, out=0x7FC00000.
REQ-035 SHALL cover running max frame {0x3F800000, 0xC0A00000, 0x40200000 last} -> single output 0x40200000; running min of same frame -> 0xC0A00000.
REQ-036 SHALL cover out_ready=0 for 3 cycles with back-to-back inputs -> in_ready=0, outputs held, no beat lost or duplicated.
REQ-037 SHALL cover rst pulse after two beats of a running frame -> no output for that frame; next frame {0x40000000 last} -> 0x40000000.
REQ-038 SHALL cover EXP_W=5, MAN_W=10: a=0x3C00, b=0x4000 -> less=1, out=0x4000; a=0x7E01 -> out=0x7E00, unord=1.

Source files
------------

// File: rtl/float_point_pkg.sv
// Shared mode encodings and canonical quiet-NaN builder for the float compare/accumulate block.
package float_point_pkg;

  typedef enum logic [1:0] {
    MODE_PAIR     = 2'b00,
    MODE_MAX      = 2'b01,
    MODE_MIN      = 2'b10,
    MODE_PAIR_ALT = 2'b11
  } mode_e;

  localparam int MAX_W = 128;

  // Sign 0, exponent all ones, mantissa MSB set; caller slices to its width.
  function automatic logic [MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

endpackage

// File: rtl/float_point_cmp_core.sv
// Combinational sign-magnitude ordering of two IEEE-style values with NaN detection.
module float_point_cmp_core #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 gt_o,
  output logic                 lt_o,
  output logic                 eq_o,
  output logic                 unord_o,
  output logic                 a_nan_o
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic           a_s, b_s, b_nan;
  logic [W-2:0]   a_mag, b_mag;

  assign a_s     = a_i[W-1];
  assign b_s     = b_i[W-1];
  assign a_mag   = a_i[W-2:0];
  assign b_mag   = b_i[W-2:0];
  assign a_nan_o = (&a_i[W-2:MAN_W]) && (|a_i[MAN_W-1:0]);
  assign b_nan   = (&b_i[W-2:MAN_W]) && (|b_i[MAN_W-1:0]);

  always_comb begin
    gt_o    = 1'b0;
    lt_o    = 1'b0;
    eq_o    = 1'b0;
    unord_o = 1'b0;
    if (a_nan_o || b_nan) begin
      unord_o = 1'b1;
    end else if (a_mag == '0 && b_mag == '0) begin
      eq_o = 1'b1;
    end else if (a_s != b_s) begin
      gt_o = !a_s;
      lt_o = a_s;
    end else if (a_mag == b_mag) begin
      eq_o = 1'b1;
    end else if ((a_mag > b_mag) ^ a_s) begin
      gt_o = 1'b1;
    end else begin
      lt_o = 1'b1;
    end
  end

endmodule

// File: rtl/float_point_cmp_acc.sv
// Two-stage float pair compare / running max-min accumulator with valid-ready handshakes.
module float_point_cmp_acc
  import float_point_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 great,
  output logic                 less,
  output logic                 equal,
  output logic                 unord
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [MAX_W-1:0] QNAN_FULL = canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  logic         stall, accept, running;
  mode_e        mode_in, eff_mode;
  logic         frame_act_q;
  mode_e        frame_mode_q;

  logic         s1_vld_q, s1_last_q, s1_first_q;
  logic [W-1:0] s1_a_q, s1_b_q;
  mode_e        s1_mode_q;

  logic [W-1:0] acc_q, acc_d, cmp_b, pair_out;
  logic         nan_q, nan_d, s1_run, take;
  logic         gt, lt, eq, un, a_nan;

  logic         out_vld_q;
  logic [W-1:0] out_q;
  logic [3:0]   flags_q;

  assign stall    = out_vld_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Mode is only sampled at frame start; 11 aliases pair compare.
  assign mode_in  = (mode_e'(mode) == MODE_PAIR_ALT) ? MODE_PAIR : mode_e'(mode);
  assign eff_mode = frame_act_q ? frame_mode_q : mode_in;
  assign running  = eff_mode != MODE_PAIR;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      frame_act_q  <= 1'b0;
      frame_mode_q <= MODE_PAIR;
    end else if (!stall) begin
      s1_vld_q <= in_valid;
      if (accept) begin
        s1_a_q     <= a;
        s1_b_q     <= b;
        s1_mode_q  <= eff_mode;
        s1_last_q  <= in_last;
        s1_first_q <= !frame_act_q;
        if (running) begin
          frame_act_q  <= !in_last;
          frame_mode_q <= eff_mode;
        end
      end
    end
  end

  assign s1_run = s1_mode_q != MODE_PAIR;
  assign cmp_b  = s1_run ? acc_q : s1_b_q;

  float_point_cmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
    .a_i(s1_a_q), .b_i(cmp_b),
    .gt_o(gt), .lt_o(lt), .eq_o(eq), .unord_o(un), .a_nan_o(a_nan)
  );

  // Strict compare keeps the earlier element on ties (+0 vs -0).
  assign take     = s1_first_q || ((s1_mode_q == MODE_MAX) ? gt : lt);
  assign acc_d    = take ? s1_a_q : acc_q;
  assign nan_d    = (s1_first_q ? 1'b0 : nan_q) | a_nan;
  assign pair_out = un ? QNAN : (lt ? s1_b_q : s1_a_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      flags_q   <= '0;
      acc_q     <= '0;
      nan_q     <= 1'b0;
    end else if (!stall) begin
      out_vld_q <= s1_vld_q && (!s1_run || s1_last_q);
      if (s1_vld_q) begin
        if (s1_run) begin
          acc_q <= acc_d;
          nan_q <= nan_d;
          if (s1_last_q) begin
            out_q   <= nan_d ? QNAN : acc_d;
            flags_q <= {3'b000, nan_d};
          end
        end else begin
          out_q   <= pair_out;
          flags_q <= {gt, lt, eq, un};
        end
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out       = out_q;
  assign {great, less, equal, unord} = flags_q;

endmodule
